// File: rtl/bridge_pkt_receiver.sv
// bridge_pkt_receiver
// Packet receiver between the UART RX byte source and the downstream packet
// RAM. Parses header / payload / check words with its own FSM, stages header
// and payload words through a small holding FIFO, and computes an XOR or
// additive check over header+payload.
//
// Ports:
//   clock       - single clock, rising edge
//   resetn      - asynchronous active-low reset
//   pkt_valid   - source presents a word on data_in
//   data_in     - header, payload or check word
//   busy        - holding buffer full; source must hold its word
//   ram_full    - downstream cannot accept this cycle
//   dout        - holding buffer head word
//   dout_valid  - dout is transferred downstream this cycle
//   dest        - addr field of the current/last header
//   pkt_done    - one-cycle pulse at packet end (normal or truncated)
//   chk_err     - check mismatch on the last packet
//   len_err     - last packet was truncated
module bridge_pkt_receiver #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int CHK_MODE   = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  input  logic              ram_full,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dest,
  output logic              pkt_done,
  output logic              chk_err,
  output logic              len_err
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  // Running check update: XOR or modulo-2^DATA_W sum.
  function automatic logic [DATA_W-1:0] chk_update(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
    if (CHK_MODE == 1) begin
      chk_update = acc + word;
    end else begin
      chk_update = acc ^ word;
    end
  endfunction

  // Pointer advance with wrap at HOLD_DEPTH (depth need not fill PTR_W).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(HOLD_DEPTH - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + PTR_W'(1);
    end
  endfunction

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [DATA_W-1:0]   chk_q, chk_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                pkt_done_q, pkt_done_d;
  logic                chk_err_q, chk_err_d;
  logic                len_err_q, len_err_d;

  logic [DATA_W-1:0]   mem_q [HOLD_DEPTH];
  logic [DATA_W-1:0]   mem_d [HOLD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                busy_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;

  // Buffer-side combinational outputs and handshake decode.
  always_comb begin
    busy_s     = (count_q == CNT_W'(HOLD_DEPTH));
    accept_s   = pkt_valid && !busy_s;
    // The check word is consumed by the FSM only, never buffered.
    push_s     = accept_s && (state_q != ST_CHECK);
    pop_s      = (count_q != '0) && !ram_full;
    busy       = busy_s;
    dout_valid = pop_s;
    dout       = mem_q[rd_ptr_q];
    dest       = dest_q;
    pkt_done   = pkt_done_q;
    chk_err    = chk_err_q;
    len_err    = len_err_q;
  end

  // Holding FIFO next-state: write at wr_ptr, read at rd_ptr, count tracks fill.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Packet FSM next-state: header parse, payload check accumulation, check compare.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    chk_d       = chk_q;
    dest_d      = dest_q;
    pkt_done_d  = 1'b0;
    chk_err_d   = chk_err_q;
    len_err_d   = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          dest_d      = data_in[ADDR_W-1:0];
          remaining_d = data_in[DATA_W-1:ADDR_W];
          chk_d       = data_in;
          chk_err_d   = 1'b0;
          len_err_d   = 1'b0;
          if (data_in[DATA_W-1:ADDR_W] != '0) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          chk_d       = chk_update(chk_q, data_in);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (!busy_s) begin
          // Source went idle mid-packet: truncation.
          len_err_d  = 1'b1;
          chk_err_d  = 1'b0;
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          chk_err_d  = (data_in != chk_q);
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (!busy_s) begin
          len_err_d  = 1'b1;
          chk_err_d  = 1'b0;
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset also discards buffered words and the partial packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      chk_q       <= '0;
      dest_q      <= '0;
      pkt_done_q  <= 1'b0;
      chk_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      chk_q       <= chk_d;
      dest_q      <= dest_d;
      pkt_done_q  <= pkt_done_d;
      chk_err_q   <= chk_err_d;
      len_err_q   <= len_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bridge_pkt_receiver.sv
// Testbench for bridge_pkt_receiver: an XOR-check instance and an additive-check
// instance share the same stimulus. A per-cycle vector table drives the XOR
// instance through good, bad-check and truncated packets; hand-written
// sequences cover the additive check, back-pressure and mid-packet reset.
module tb_bridge_pkt_receiver;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       ram_full;

  logic       x_busy, x_dv, x_done, x_cerr, x_lerr;
  logic [7:0] x_dout;
  logic [1:0] x_dest;
  logic       a_busy, a_dv, a_done, a_cerr, a_lerr;
  logic [7:0] a_dout;
  logic [1:0] a_dest;

  int tests  = 0;
  int errors = 0;

  logic [7:0] q_x[$];
  logic [7:0] q_a[$];

  bridge_pkt_receiver #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(2), .CHK_MODE(0)) u_xor (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(x_busy), .ram_full(ram_full), .dout(x_dout), .dout_valid(x_dv),
    .dest(x_dest), .pkt_done(x_done), .chk_err(x_cerr), .len_err(x_lerr)
  );

  bridge_pkt_receiver #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(2), .CHK_MODE(1)) u_add (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(a_busy), .ram_full(ram_full), .dout(a_dout), .dout_valid(a_dv),
    .dest(a_dest), .pkt_done(a_done), .chk_err(a_cerr), .len_err(a_lerr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Collect every word transferred downstream by each instance.
  always @(negedge clock) begin
    if (resetn && x_dv) q_x.push_back(x_dout);
    if (resetn && a_dv) q_a.push_back(a_dout);
  end

  typedef struct {
    logic       pv;
    logic [7:0] d;
    logic       rf;
    logic       busy;
    logic       dv;
    logic [7:0] dout;
    logic       done;
    logic       cerr;
    logic       lerr;
    logic [1:0] dest;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({name, " count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s word%0d", name, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    pkt_valid = 1'b1;
    data_in   = w;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [7:0] bp_w[5];
  logic [7:0] exp_q[$];
  int         idx;
  int         cyc;
  logic       b;

  initial begin
    // pv, d, rf | busy, dv, dout, done, cerr, lerr, dest
    // good XOR packet
    vecs[0]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[4]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1};
    // bad check word
    vecs[6]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 8'h0E, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1};
    // truncation after one payload word
    vecs[13] = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[14] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1};
    // good packet clears len_err
    vecs[18] = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[19] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[20] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[21] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[22] = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1};

    // Reset state
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    ram_full  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst dout", 32'(x_dout), 32'h0);
    check("rst dout_valid", 32'(x_dv), 32'h0);
    check("rst busy", 32'(x_busy), 32'h0);
    check("rst dest", 32'(x_dest), 32'h0);
    check("rst pkt_done", 32'(x_done), 32'h0);
    check("rst chk_err", 32'(x_cerr), 32'h0);
    check("rst len_err", 32'(x_lerr), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Vector table on the XOR instance
    for (int i = 0; i < NV; i++) begin
      pkt_valid = vecs[i].pv;
      data_in   = vecs[i].d;
      ram_full  = vecs[i].rf;
      @(negedge clock);
      check($sformatf("row%0d busy", i), 32'(x_busy), 32'(vecs[i].busy));
      check($sformatf("row%0d dout_valid", i), 32'(x_dv), 32'(vecs[i].dv));
      if (vecs[i].dv) check($sformatf("row%0d dout", i), 32'(x_dout), 32'(vecs[i].dout));
      check($sformatf("row%0d pkt_done", i), 32'(x_done), 32'(vecs[i].done));
      check($sformatf("row%0d chk_err", i), 32'(x_cerr), 32'(vecs[i].cerr));
      check($sformatf("row%0d len_err", i), 32'(x_lerr), 32'(vecs[i].lerr));
      check($sformatf("row%0d dest", i), 32'(x_dest), 32'(vecs[i].dest));
      @(posedge clock);
      #1;
    end

    // Zero-length packet and additive check
    q_a.delete();
    send_word(8'h02);
    send_word(8'h02);
    pkt_valid = 1'b0;
    @(negedge clock);
    check("add zl pkt_done", 32'(a_done), 32'h1);
    check("add zl chk_err", 32'(a_cerr), 32'h0);
    check("add zl len_err", 32'(a_lerr), 32'h0);
    check("add zl dest", 32'(a_dest), 32'h2);
    @(posedge clock);
    #1;
    send_word(8'h0D);
    send_word(8'hF0);
    send_word(8'h20);
    send_word(8'h01);
    send_word(8'h1E);
    pkt_valid = 1'b0;
    @(negedge clock);
    check("add sum pkt_done", 32'(a_done), 32'h1);
    check("add sum chk_err", 32'(a_cerr), 32'h0);
    check("add sum dest", 32'(a_dest), 32'h1);
    check("xor same pkt chk_err", 32'(x_cerr), 32'h1);
    @(posedge clock);
    #1;
    idle_cycles(3);
    exp_q = '{8'h02, 8'h0D, 8'hF0, 8'h20, 8'h01};
    check_q("add dout seq", q_a, exp_q);

    // Back-pressure: ram_full high for 5 cycles during a good packet
    q_x.delete();
    bp_w = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 40) begin
      ram_full  = (cyc >= 1 && cyc <= 5);
      pkt_valid = 1'b1;
      data_in   = bp_w[idx];
      @(negedge clock);
      b = x_busy;
      if (cyc == 1) check("bp busy one word", 32'(b), 32'h0);
      if (cyc == 2) check("bp busy two words", 32'(b), 32'h1);
      if (cyc == 5) check("bp busy held", 32'(b), 32'h1);
      if (cyc == 6) check("bp busy at release", 32'(b), 32'h1);
      if (cyc == 7) check("bp busy after release", 32'(b), 32'h0);
      @(posedge clock);
      if (!b) idx++;
      #1;
      cyc++;
    end
    check("bp all words accepted", 32'(idx), 32'd5);
    check("bp cycles used", 32'(cyc), 32'd10);
    pkt_valid = 1'b0;
    ram_full  = 1'b0;
    @(negedge clock);
    check("bp pkt_done", 32'(x_done), 32'h1);
    check("bp chk_err", 32'(x_cerr), 32'h0);
    check("bp len_err", 32'(x_lerr), 32'h0);
    @(posedge clock);
    #1;
    idle_cycles(3);
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
    check_q("bp dout seq", q_x, exp_q);

    // Reset mid-packet with buffered words
    ram_full = 1'b1;
    send_word(8'h0D);
    send_word(8'h11);
    send_word(8'h22);
    check("pre-rst busy", 32'(x_busy), 32'h1);
    resetn = 1'b0;
    #1;
    q_x.delete();
    check("mid rst dout", 32'(x_dout), 32'h0);
    check("mid rst dout_valid", 32'(x_dv), 32'h0);
    check("mid rst busy", 32'(x_busy), 32'h0);
    check("mid rst dest", 32'(x_dest), 32'h0);
    check("mid rst pkt_done", 32'(x_done), 32'h0);
    check("mid rst chk_err", 32'(x_cerr), 32'h0);
    check("mid rst len_err", 32'(x_lerr), 32'h0);
    check("mid rst add busy", 32'(a_busy), 32'h0);
    pkt_valid = 1'b0;
    ram_full  = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    send_word(8'h0D);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h0D);
    pkt_valid = 1'b0;
    @(negedge clock);
    check("post rst pkt_done", 32'(x_done), 32'h1);
    check("post rst chk_err", 32'(x_cerr), 32'h0);
    check("post rst len_err", 32'(x_lerr), 32'h0);
    @(posedge clock);
    #1;
    idle_cycles(3);
    exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33};
    check_q("post rst dout seq", q_x, exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
